// File: rtl/store_merge_unit_pkg.sv
// ---------------------------------------------------------------------------
// store_merge_unit_pkg
//
// Shared definitions for the store merge unit:
//   size_e   - store size encodings as carried on req_size
//   state_e  - control FSM state encoding
//   store_is_bad() - misalignment / reserved-size decode used at accept time
// ---------------------------------------------------------------------------
package store_merge_unit_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // A store is rejected when its size is reserved or its address is not
    // naturally aligned for that size. Bytes are always aligned.
    function automatic logic store_is_bad(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// ---------------------------------------------------------------------------
// store_lane_merge
//
// Purely combinational little-endian lane merge of a sub-word store into an
// existing memory word.
//
// Ports:
//   old_word [31:0] in  - word currently held in memory
//   data     [31:0] in  - store register value (only low 8/16/32 bits used)
//   addr_lo  [1:0]  in  - byte offset of the store within the word
//   size            in  - store size (size_e)
//   merged   [31:0] out - word with the addressed lanes replaced
// ---------------------------------------------------------------------------
module store_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        addr_lo,
    input  size_e             size,
    output logic [DATA_W-1:0] merged
);

    // Each byte lane independently picks its source. A halfword store feeds
    // lanes 0/2 from data[7:0] and lanes 1/3 from data[15:8]; the upper data
    // bits only ever reach memory on a full word store. A reserved size
    // replaces nothing.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic sel_byte;
            logic sel_half;
            logic sel_word;

            assign sel_byte = (size == SZ_BYTE) && (addr_lo == LANE);
            assign sel_half = (size == SZ_HALF) && (addr_lo[1] == LANE[1]);
            assign sel_word = (size == SZ_WORD);

            assign merged[8*gi +: 8] = sel_byte ? data[7:0]
                                     : sel_half ? data[8*(gi%2) +: 8]
                                     : sel_word ? data[8*gi +: 8]
                                     : old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/store_merge_unit.sv
// ---------------------------------------------------------------------------
// store_merge_unit
//
// Turns byte / halfword / word store requests into word-wide memory
// accesses. Sub-word stores perform a read-modify-write: the containing
// word is read, the addressed lanes are replaced, and the merged word is
// written back. Word stores skip the read. Misaligned stores and the
// reserved size finish immediately with err=1 and never touch memory.
//
// Ports:
//   clk            in  - clock, all state updates on the rising edge
//   rst_n          in  - synchronous active-low reset
//   req_valid      in  - store request present
//   req_ready      out - unit is idle and can accept a request
//   req_addr       in  - byte address of the store (ADDR_W bits)
//   req_data       in  - store register value
//   req_size       in  - 00 byte, 01 half, 10 word, 11 reserved
//   done           out - one-cycle completion pulse
//   err            out - with done: store rejected, memory untouched
//   mem_addr       out - word-aligned memory address (0 when not accessing)
//   mem_rd_en      out - one-cycle read strobe
//   mem_rd_valid   in  - read data valid (only looked at while waiting)
//   mem_rd_data    in  - read word
//   mem_wr_en      out - write request, held until acknowledged
//   mem_wr_data    out - word to write
//   mem_wr_ack     in  - write accepted this cycle
// ---------------------------------------------------------------------------
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,

    output logic              done,
    output logic              err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ack
);

    state_e              state_reg;
    state_e              state_next;

    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    size_e               size_reg;
    logic                err_reg;
    logic [DATA_W-1:0]   wdata_reg;

    size_e               req_size_dec;
    logic                req_bad;
    logic                accept;
    logic [ADDR_W-1:0]   word_addr;
    logic [DATA_W-1:0]   merged_word;

    assign req_size_dec = size_e'(req_size);
    assign req_bad      = store_is_bad(req_size_dec, req_addr[1:0]);
    assign accept       = (state_reg == ST_IDLE) && req_valid;
    assign word_addr    = {addr_reg[ADDR_W-1:2], 2'b00};
    assign mem_wr_data  = wdata_reg;

    store_lane_merge u_merge (
        .old_word (mem_rd_data),
        .data     (data_reg),
        .addr_lo  (addr_reg[1:0]),
        .size     (size_reg),
        .merged   (merged_word)
    );

    // -----------------------------------------------------------------------
    // State and request registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            size_reg  <= SZ_BYTE;
            err_reg   <= 1'b0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                addr_reg  <= req_addr;
                data_reg  <= req_data;
                size_reg  <= req_size_dec;
                err_reg   <= req_bad;
                // Word stores write the register value straight through;
                // sub-word stores overwrite this once the read returns.
                wdata_reg <= req_data;
            end

            if ((state_reg == ST_RD_WAIT) && mem_rd_valid) begin
                wdata_reg <= merged_word;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and Moore outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_addr   = '0;

        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_next = ST_DONE;
                    end else if (req_size_dec == SZ_WORD) begin
                        state_next = ST_WR;
                    end else begin
                        state_next = ST_RD_REQ;
                    end
                end
            end

            ST_RD_REQ: begin
                mem_rd_en  = 1'b1;
                mem_addr   = word_addr;
                state_next = ST_RD_WAIT;
            end

            // No timeout: the memory is trusted to answer eventually.
            ST_RD_WAIT: begin
                mem_addr = word_addr;
                if (mem_rd_valid) begin
                    state_next = ST_WR;
                end
            end

            ST_WR: begin
                mem_wr_en = 1'b1;
                mem_addr  = word_addr;
                if (mem_wr_ack) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                done       = 1'b1;
                err        = err_reg;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;
    import store_merge_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ack = 1'b0;

    always #5 clk = ~clk;

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .done         (done),
        .err          (err),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ack   (mem_wr_ack)
    );

    // Reference lane merge, checked against hand-derived words below.
    logic [31:0] ref_old;
    logic [31:0] ref_data;
    logic [1:0]  ref_lo;
    size_e       ref_size;
    logic [31:0] ref_out;

    store_lane_merge u_ref (
        .old_word (ref_old),
        .data     (ref_data),
        .addr_lo  (ref_lo),
        .size     (ref_size),
        .merged   (ref_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected completions
    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic sb_push(input logic e, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        x.err  = e;
        x.addr = a;
        x.data = d;
        sb_q.push_back(x);
    endtask

    // Memory responder
    logic [31:0] mem_word = '0;
    int          rd_delay = 0;
    int          ack_delay = 0;
    int          rd_left = 0;
    int          wr_seen = 0;

    assign mem_rd_data = mem_word;

    always @(posedge clk) begin
        #1;
        if (mem_rd_en) begin
            rd_left      = rd_delay + 1;
            mem_rd_valid = 1'b0;
        end else if (rd_left > 0) begin
            rd_left--;
            mem_rd_valid = (rd_left == 0);
        end else begin
            mem_rd_valid = 1'b0;
        end
        if (mem_wr_en) begin
            mem_wr_ack = (wr_seen == ack_delay);
            wr_seen++;
        end else begin
            wr_seen    = 0;
            mem_wr_ack = 1'b0;
        end
    end

    // Monitor
    int          cyc = 0;
    int          acc_cyc = 0;
    int          acc_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cyc_cnt = 0;
    int          wr_run = 0;
    int          ack_cyc = 0;
    int          done_cyc = 0;
    int          prev_done_cyc = 0;
    int          done_cnt = 0;
    logic [31:0] wr_first_d = '0;
    logic [31:0] wr_first_a = '0;
    logic [31:0] last_wd = '0;
    logic [31:0] last_wa = '0;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            wr_run = 0;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                acc_cnt++;
            end
            if (mem_rd_en) rd_cnt++;
            if (mem_wr_en) begin
                wr_cyc_cnt++;
                if (wr_run == 0) begin
                    wr_first_d = mem_wr_data;
                    wr_first_a = mem_addr;
                end else begin
                    chk("wr_data_stable", mem_wr_data, wr_first_d);
                    chk("wr_addr_stable", mem_addr, wr_first_a);
                end
                wr_run++;
                if (mem_wr_ack) begin
                    ack_cyc = cyc;
                    last_wd = mem_wr_data;
                    last_wa = mem_addr;
                end
            end else begin
                wr_run = 0;
            end
            if (mem_rd_en || mem_wr_en || done)
                chk("strobe_exclusive", int'(mem_rd_en) + int'(mem_wr_en) + int'(done), 1);
            if (err) chk("err_only_with_done", done, 1'b1);
            if (done) begin
                prev_done_cyc = done_cyc;
                done_cyc      = cyc;
                done_cnt++;
                chk("sb_has_entry_at_done", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("done_err", err, mon_e.err);
                    if (!mon_e.err) begin
                        chk("wr_data", last_wd, mon_e.data);
                        chk("wr_addr", last_wa, mon_e.addr);
                    end
                    $display("txn cyc=%0d done err=%0b wr_addr=%08h wr_data=%08h", cyc, err, last_wa, last_wd);
                end
            end
        end
    end

    // Stimulus helpers
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        chk("accepted", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n;
        n = 0;
        while (done_cnt == start && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt != start, 1'b1);
    endtask

    // Run one store and check read count, write-cycle count and latency
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                             input logic [31:0] mword, input int ackd,
                             input logic e, input logic [31:0] ea, input logic [31:0] ed,
                             input int exp_rd, input int exp_wr_cyc, input int exp_lat);
        int r0, w0, d0;
        mem_word  = mword;
        ack_delay = ackd;
        r0 = rd_cnt;
        w0 = wr_cyc_cnt;
        d0 = done_cnt;
        sb_push(e, ea, ed);
        issue(a, d, s);
        wait_done(d0);
        chk("rd_count", rd_cnt - r0, exp_rd);
        chk("wr_cycles", wr_cyc_cnt - w0, exp_wr_cyc);
        chk("latency", done_cyc - acc_cyc, exp_lat);
    endtask

    initial begin : main
        int d0, w0, a0, n;

        // Reference merge sanity
        ref_old = 32'h11223344; ref_data = 32'hFFFFFFAB; ref_lo = 2'd3; ref_size = SZ_BYTE;
        #1 chk("ref_sb_lane3", ref_out, 32'hAB223344);
        ref_lo = 2'd0; ref_size = SZ_HALF;
        #1 chk("ref_sh_low", ref_out, 32'h1122FFAB);
        ref_size = SZ_RSVD;
        #1 chk("ref_rsvd_keeps", ref_out, 32'h11223344);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_wr_data", mem_wr_data, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", req_ready, 1'b1);

        // sb: one read, merged lane 1
        run_store(32'h101, 32'hDEADBEEF, SZ_BYTE, 32'h11223344, 0,
                  1'b0, 32'h100, 32'h1122EF44, 1, 1, 4);
        // sh with delayed ack: wr_en held 4 cycles, done one cycle after ack
        run_store(32'h202, 32'h0000ABCD, SZ_HALF, 32'h55667788, 3,
                  1'b0, 32'h200, 32'hABCD7788, 1, 4, 7);
        chk("done_after_ack", done_cyc - ack_cyc, 1);
        // sw: no read, data through unchanged
        run_store(32'h300, 32'hCAFEF00D, SZ_WORD, 32'h99999999, 0,
                  1'b0, 32'h300, 32'hCAFEF00D, 0, 1, 2);
        // Misaligned and reserved: immediate error, no memory traffic
        run_store(32'h401, 32'h12345678, SZ_HALF, 32'h0, 0,
                  1'b1, 32'h0, 32'h0, 0, 0, 1);
        run_store(32'h402, 32'h12345678, SZ_WORD, 32'h0, 0,
                  1'b1, 32'h0, 32'h0, 0, 0, 1);
        run_store(32'h500, 32'h12345678, 2'b11, 32'h0, 0,
                  1'b1, 32'h0, 32'h0, 0, 0, 1);
        // Upper data bits ignored on sub-word stores
        run_store(32'h200, 32'hFFFF1234, SZ_HALF, 32'h55667788, 0,
                  1'b0, 32'h200, 32'h55661234, 1, 1, 4);
        run_store(32'h703, 32'h123456AB, SZ_BYTE, 32'h11223344, 1,
                  1'b0, 32'h700, 32'hAB223344, 1, 2, 5);

        // Reset during RD_WAIT abandons the store
        rd_delay = 3;
        d0 = done_cnt;
        w0 = wr_cyc_cnt;
        issue(32'h101, 32'hDEADBEEF, SZ_BYTE);
        @(posedge clk);
        #1 chk("in_rd_wait_addr", mem_addr, 32'h100);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rd_en", mem_rd_en, 1'b0);
        chk("midrst_wr_en", mem_wr_en, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_wr_data", mem_wr_data, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_midrst", req_ready, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_write", wr_cyc_cnt - w0, 0);
        chk("midrst_no_done", done_cnt - d0, 0);
        rd_delay = 0;

        // Back-to-back with req_valid held high
        mem_word  = 32'hAAAAAAAA;
        ack_delay = 0;
        d0 = done_cnt;
        a0 = acc_cnt;
        sb_push(1'b0, 32'h500, 32'h01020304);
        sb_push(1'b0, 32'h600, 32'hAAAA77AA);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_addr = 32'h500; req_data = 32'h01020304; req_size = SZ_WORD;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        @(posedge clk);
        #1;
        req_addr = 32'h601; req_data = 32'h00000077; req_size = SZ_BYTE;
        wait_done(d0);
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done(d0 + 1);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_accepts", acc_cnt - a0, 2);
        chk("b2b_dones", done_cnt - d0, 2);
        chk("b2b_second_accept", acc_cyc - prev_done_cyc, 1);

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
